alu_cmd_ctrl: RTL
=================

# alu_cmd_ctrl

Command-side controller for the ALU datapath: the initiator that drives the ALU enable/function/operand inputs and consumes the ALU result and its valid flag. It parses byte-framed commands from the serial receive path, issues one ALU operation per command, captures the result and returns it as two bytes to the serial transmit path. It sits between the UART RX/TX byte interfaces and the ALU top, all in the ALU clock domain.

## Interface
- DATA_W, 8, byte and operand width
- RES_W, 16, ALU result width; must equal 2*DATA_W
- TIMEOUT, 15, cycles to wait for alu_valid before aborting

- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- rx_data  input  DATA_W  received byte
- rx_valid  input  1  one-cycle strobe per received byte
- alu_a  output  DATA_W  operand A, registered
- alu_b  output  DATA_W  operand B, registered
- alu_fun  output  4  ALU function code, passed through unchanged
- alu_en  output  1  ALU enable, held until result seen
- alu_out  input  RES_W  ALU result
- alu_valid  input  1  ALU result flag
- tx_data  output  DATA_W  byte to transmit
- tx_valid  output  1  tx_data valid; held until accepted
- tx_busy  input  1  transmitter cannot accept
- cmd_err  output  1  one-cycle pulse: bad opcode or ALU timeout
- rx_drop  output  1  one-cycle pulse: byte received while busy, discarded

## Operation
- Opcodes: 0xCC = operate with new operands (frame CC, A, B, FUN); 0xDD = operate with stored operands (frame DD, FUN). Only FUN[3:0] is used.
- States: IDLE, GET_A, GET_B, GET_FUN, WAIT_RES, SEND_LO, SEND_HI.
- IDLE + rx_valid: 0xCC -> GET_A; 0xDD -> GET_FUN; any other byte -> cmd_err pulse, stay IDLE.
- GET_A / GET_B on rx_valid: load alu_a / alu_b, advance. GET_FUN on rx_valid: load alu_fun, set alu_en, clear timeout counter -> WAIT_RES.
- WAIT_RES: alu_en=1; counter increments each cycle. alu_valid=1 -> capture alu_out into result register, alu_en=0, -> SEND_LO. Counter reaching TIMEOUT without alu_valid -> alu_en=0, cmd_err pulse, -> IDLE, no bytes sent.
- SEND_LO: tx_valid=1, tx_data=result[7:0]; on tx_valid&&!tx_busy -> SEND_HI. SEND_HI: tx_data=result[15:8]; on accept -> IDLE, tx_valid=0.
- rx_valid in WAIT_RES/SEND_LO/SEND_HI: byte discarded, rx_drop pulse, state unaffected.
- Operand registers persist across commands; a DD frame after reset uses A=B=0.
- alu_valid outside WAIT_RES is ignored.
- Reset (any time, including mid-frame or mid-send): state IDLE; all outputs, operand, result and counter registers 0; no partial byte is reissued.

## Timing
- All outputs registered.
- FUN byte strobed in cycle N -> alu_en=1 from N+1. With a one-cycle ALU, alu_valid visible at N+2 -> alu_en=0 and tx_valid=1 (low byte) from N+3.
- tx_valid and tx_data stable while tx_busy=1; a byte is accepted in the cycle tx_valid=1 and tx_busy=0. The high byte is presented the cycle after low-byte acceptance, earliest.
- Back-to-back frames: the first byte of the next frame is accepted in the cycle after SEND_HI completes (IDLE).
- cmd_err and rx_drop are exactly one cycle wide.

## Structure
- Shared package/header alu_ctrl_pkg: CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD, state encodings, default TIMEOUT.
- One sub-module: alu_resp_timer (clear, enable, expire at TIMEOUT), instantiated once; everything else in a single FSM.

## Test plan
- Frame CC,0x0F,0x33,0x1 with ALU returning 0x003F two cycles later -> alu_a=0x0F, alu_b=0x33, alu_fun=1, alu_en high 2 cycles, tx bytes 0x3F then 0x00.
- Frame DD,0x0 after the above, ALU returning 0x0003 -> operands still 0x0F/0x33, tx bytes 0x03, 0x00.
- Opcode byte 0x55 in IDLE -> single cmd_err pulse, no alu_en, next CC frame processed normally.
- alu_valid held low after FUN byte -> alu_en drops and cmd_err pulses 15 cycles after alu_en rises; tx_valid never asserted.
- tx_busy=1 for 5 cycles during SEND_LO, plus rx_valid byte 0xAA during SEND_LO -> tx_data stays at the low byte, one rx_drop pulse, both bytes sent once in order.
- rst low during GET_B and again during SEND_HI -> all outputs 0 immediately, state IDLE, no further tx byte.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_pkg
//  Description : Shared command opcodes, controller states and timeout default
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // frame: CC, A, B, FUN
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // frame: DD, FUN (stored operands)

  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_A    = 3'd1,
    ST_GET_B    = 3'd2,
    ST_GET_FUN  = 3'd3,
    ST_WAIT_RES = 3'd4,
    ST_SEND_LO  = 3'd5,
    ST_SEND_HI  = 3'd6
  } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_ctrl_if
//  Description : Byte RX/TX and ALU request/result bundle of the controller
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16
) ();

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_fun;
  logic              alu_en;
  logic [RES_W-1:0]  alu_out;
  logic              alu_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_busy;
  logic              cmd_err;
  logic              rx_drop;

  modport master (
    input  rx_data, rx_valid, alu_out, alu_valid, tx_busy,
    output alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, cmd_err, rx_drop
  );

  modport slave (
    output rx_data, rx_valid, alu_out, alu_valid, tx_busy,
    input  alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, cmd_err, rx_drop
  );

endinterface
`default_nettype wire

// File: rtl/alu_resp_timer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_resp_timer
//  Description : Counts cycles spent waiting for the ALU result
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_resp_timer #(
  parameter int TIMEOUT = 15
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  clear,
  input  wire  enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // Fires in the last waiting cycle, so the count would reach TIMEOUT on this edge
  assign expire = enable && (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_ctrl
//  Description : Parses byte commands, drives one ALU operation, returns result
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  wire             clk,
  input  wire             rst,
  alu_cmd_ctrl_if.master  bus
);

  ctrl_state_t       r_state;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [3:0]        r_alu_fun;
  logic              r_alu_en;
  logic [RES_W-1:0]  r_result;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_cmd_err;
  logic              r_rx_drop;

  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_expire;
  logic w_tx_accept;

  assign w_tmr_clr   = (r_state == ST_GET_FUN) && bus.rx_valid;
  assign w_tmr_en    = (r_state == ST_WAIT_RES);
  assign w_tx_accept = r_tx_valid && !bus.tx_busy;

  alu_resp_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_tmr_clr),
    .enable (w_tmr_en),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_fun  <= '0;
      r_alu_en   <= 1'b0;
      r_result   <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_rx_drop  <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      r_rx_drop <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == CMD_ALU_OP) begin
              r_state <= ST_GET_A;
            end else if (bus.rx_data == CMD_ALU_NOP) begin
              r_state <= ST_GET_FUN;
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
        end
        ST_GET_A: begin
          if (bus.rx_valid) begin
            r_alu_a <= bus.rx_data;
            r_state <= ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (bus.rx_valid) begin
            r_alu_b <= bus.rx_data;
            r_state <= ST_GET_FUN;
          end
        end
        ST_GET_FUN: begin
          if (bus.rx_valid) begin
            r_alu_fun <= bus.rx_data[3:0];
            r_alu_en  <= 1'b1;
            r_state   <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          r_rx_drop <= bus.rx_valid;
          // A result arriving in the final waiting cycle still wins over the timeout
          if (bus.alu_valid) begin
            r_result   <= bus.alu_out;
            r_alu_en   <= 1'b0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= bus.alu_out[DATA_W-1:0];
            r_state    <= ST_SEND_LO;
          end else if (w_expire) begin
            r_alu_en  <= 1'b0;
            r_cmd_err <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_SEND_LO: begin
          r_rx_drop <= bus.rx_valid;
          if (w_tx_accept) begin
            r_tx_data <= r_result[RES_W-1:DATA_W];
            r_state   <= ST_SEND_HI;
          end else begin
            r_tx_data <= r_result[DATA_W-1:0];
          end
        end
        ST_SEND_HI: begin
          r_rx_drop <= bus.rx_valid;
          if (w_tx_accept) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.alu_a    = r_alu_a;
  assign bus.alu_b    = r_alu_b;
  assign bus.alu_fun  = r_alu_fun;
  assign bus.alu_en   = r_alu_en;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.cmd_err  = r_cmd_err;
  assign bus.rx_drop  = r_rx_drop;

endmodule
`default_nettype wire
